// File: rtl/hart_mem_arbiter.sv
// Round-robin arbiter that multiplexes per-hart data-memory requests onto one
// downstream port, holding the grant for a full transaction, with a watchdog abort.
module hart_mem_arbiter #(
  parameter int N_HARTS = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [N_HARTS-1:0]   w_req,
  input  logic [N_HARTS-1:0]   w_we,
  input  logic [N_HARTS*32-1:0] w_addr,
  input  logic [N_HARTS*DW-1:0] w_wdata,
  input  logic [N_HARTS*3-1:0] w_ctrl,
  output logic [N_HARTS-1:0]   w_grant,
  output logic [N_HARTS-1:0]   w_done,
  output logic [N_HARTS-1:0]   w_err,
  output logic [DW-1:0]        w_rdata,
  output logic                 w_mem_req,
  output logic                 w_mem_we,
  output logic [31:0]          w_mem_addr,
  output logic [DW-1:0]        w_mem_wdata,
  output logic [2:0]           w_mem_ctrl,
  input  logic                 w_mem_busy,
  input  logic [DW-1:0]        w_mem_rdata
);

  localparam int IW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LP_TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit LP_WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_last;
  logic [CW-1:0]     r_cnt;
  logic [N_HARTS-1:0] r_grant;
  logic [N_HARTS-1:0] r_done;
  logic [N_HARTS-1:0] r_err;
  logic [DW-1:0]     r_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic [2:0]        r_mem_ctrl;

  logic              w_any;
  logic [IW-1:0]     w_sel;
  int                w_best;
  logic [N_HARTS-1:0] w_sel_oh;
  logic              w_sel_we;
  logic [31:0]       w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;
  logic [2:0]        w_sel_ctrl;
  logic              w_abort;

  // Distance from last_grant+1 (mod N); the requester closest to it wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_best = N_HARTS;
    for (int j = 0; j < N_HARTS; j++) begin
      if (w_req[j] && (((j + 2*N_HARTS - 1 - int'(r_last)) % N_HARTS) < w_best)) begin
        w_best = (j + 2*N_HARTS - 1 - int'(r_last)) % N_HARTS;
        w_any  = 1'b1;
        w_sel  = IW'(j);
      end
    end
  end

  always_comb begin
    w_sel_oh    = '0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_ctrl  = '0;
    for (int j = 0; j < N_HARTS; j++) begin
      if (w_sel == IW'(j)) begin
        w_sel_oh[j] = 1'b1;
        w_sel_we    = w_we[j];
        w_sel_addr  = w_addr[32*j +: 32];
        w_sel_wdata = w_wdata[DW*j +: DW];
        w_sel_ctrl  = w_ctrl[3*j +: 3];
      end
    end
  end

  assign w_abort = (r_state == S_WAIT) && w_mem_busy && LP_WDOG_EN && (r_cnt == LP_TLAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (!w_mem_busy || w_abort) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Every output is a register so downstream and harts see glitch-free strobes.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_last      <= IW'(N_HARTS - 1);
      r_cnt       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_ctrl  <= '0;
    end else begin
      r_mem_req <= 1'b0;
      r_done    <= '0;
      r_err     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant     <= w_sel_oh;
            r_last      <= w_sel;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_ctrl  <= w_sel_ctrl;
          end else begin
            r_grant <= '0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (!w_mem_busy) begin
            r_rdata <= w_mem_rdata;
            r_done  <= r_grant;
          end else if (w_abort) begin
            r_rdata <= '0;
            r_done  <= r_grant;
            r_err   <= r_grant;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_grant <= '0;
        default: r_grant <= '0;
      endcase
    end
  end

  assign w_grant     = r_grant;
  assign w_done      = r_done;
  assign w_err       = r_err;
  assign w_rdata     = r_rdata;
  assign w_mem_req   = r_mem_req;
  assign w_mem_we    = r_mem_we;
  assign w_mem_addr  = r_mem_addr;
  assign w_mem_wdata = r_mem_wdata;
  assign w_mem_ctrl  = r_mem_ctrl;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Bench for hart_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin / latency model.
module tb_hart_mem_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic [N-1:0]  w_req = '0;
  logic [N-1:0]  w_we = '0;
  logic [N*32-1:0] w_addr = '0;
  logic [N*DW-1:0] w_wdata = '0;
  logic [N*3-1:0] w_ctrl = '0;
  logic [N-1:0]  w_grant, w_done, w_err;
  logic [DW-1:0] w_rdata;
  logic          w_mem_req, w_mem_we;
  logic [31:0]   w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic [2:0]    w_mem_ctrl;
  logic          w_mem_busy = 1'b1;
  logic [DW-1:0] w_mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int last_model = N - 1;

  logic        e_we   [N];
  logic [31:0] e_addr [N];
  logic [31:0] e_wdata[N];
  logic [2:0]  e_ctrl [N];

  typedef struct {
    logic [N-1:0] grant;
    int           issue_cyc;
    int           done_cyc;
    logic [N-1:0] done;
    logic [N-1:0] err;
    logic [31:0]  rdata;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [2:0]   ctrl;
    int           req_pulses;
    bit           stable;
    bit           hung;
  } txn_t;

  hart_mem_arbiter #(.N_HARTS(N), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_we(w_we), .w_addr(w_addr),
    .w_wdata(w_wdata), .w_ctrl(w_ctrl), .w_grant(w_grant), .w_done(w_done),
    .w_err(w_err), .w_rdata(w_rdata), .w_mem_req(w_mem_req), .w_mem_we(w_mem_we),
    .w_mem_addr(w_mem_addr), .w_mem_wdata(w_mem_wdata), .w_mem_ctrl(w_mem_ctrl),
    .w_mem_busy(w_mem_busy), .w_mem_rdata(w_mem_rdata)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Round-robin reference: first requester after the last served hart.
  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_hart(input int h, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c);
    w_we[h] = we;
    w_addr[32*h +: 32] = a;
    w_wdata[DW*h +: DW] = d;
    w_ctrl[3*h +: 3] = c;
    e_we[h] = we; e_addr[h] = a; e_wdata[h] = d; e_ctrl[h] = c;
  endtask

  // Drives the downstream side for one transaction and records what was observed.
  task automatic run_txn(input int busy_n, input logic [31:0] rd, input bit scramble,
                         output txn_t t);
    int cyc; bit issued; bit fin; int iss; int k;
    cyc = 0; issued = 0; fin = 0; iss = 0;
    t.grant = '0; t.issue_cyc = -1; t.done_cyc = -1; t.done = '0; t.err = '0;
    t.rdata = '0; t.we = 0; t.addr = '0; t.wdata = '0; t.ctrl = '0;
    t.req_pulses = 0; t.stable = 1; t.hung = 0;
    w_mem_busy = 1'b1;
    while (cyc < 60 && !fin) begin
      @(posedge CLK); #1; cyc++;
      if (w_mem_req) begin
        t.req_pulses++;
        if (!issued) begin
          issued = 1; iss = cyc; t.issue_cyc = cyc; t.grant = w_grant;
          t.we = w_mem_we; t.addr = w_mem_addr; t.wdata = w_mem_wdata; t.ctrl = w_mem_ctrl;
        end
      end else if (issued) begin
        if (w_mem_we !== t.we || w_mem_addr !== t.addr || w_mem_wdata !== t.wdata ||
            w_mem_ctrl !== t.ctrl || w_grant !== t.grant) t.stable = 0;
      end
      if (w_done !== '0) begin
        fin = 1; t.done_cyc = cyc; t.done = w_done; t.err = w_err; t.rdata = w_rdata;
        w_mem_busy = 1'b1;
      end else if (issued) begin
        k = cyc - iss - 1;
        if (k >= 0) begin
          w_mem_busy  = (k < busy_n);
          w_mem_rdata = (k < busy_n) ? $urandom : rd;
        end
        if (scramble) begin
          w_addr = {$urandom, $urandom}; w_wdata = {$urandom, $urandom};
          w_we = 2'($urandom); w_ctrl = 6'($urandom);
        end
      end
    end
    if (!fin) t.hung = 1;
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (w_grant !== '0) begin failures++; $display("FAIL rst_grant got=%b exp=0", w_grant); end
    checks++; if (w_done !== '0 || w_err !== '0) begin failures++; $display("FAIL rst_done_err got=%b/%b exp=0", w_done, w_err); end
    checks++; if (w_rdata !== '0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", w_rdata); end
    checks++; if (w_mem_req !== 1'b0 || w_mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_req_we got=%b%b exp=00", w_mem_req, w_mem_we); end
    checks++; if (w_mem_addr !== '0 || w_mem_wdata !== '0 || w_mem_ctrl !== '0) begin failures++; $display("FAIL rst_mem_fields got=%h/%h/%h exp=0", w_mem_addr, w_mem_wdata, w_mem_ctrl); end
    @(negedge CLK); RST_X = 1'b1;
    last_model = N - 1;
    tick();
  endtask

  task automatic test_single_write();
    txn_t t;
    set_hart(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010);
    w_req = 2'b01;
    run_txn(0, 32'h0, 0, t);
    checks++; if (t.hung) begin failures++; $display("FAIL sw_hung got=hung exp=done"); end
    checks++; if (t.grant !== 2'b01) begin failures++; $display("FAIL sw_grant got=%b exp=01", t.grant); end
    checks++; if (t.issue_cyc !== 1 || t.done_cyc !== 3) begin failures++; $display("FAIL sw_latency got=%0d/%0d exp=1/3", t.issue_cyc, t.done_cyc); end
    checks++; if (t.done !== 2'b01 || t.err !== 2'b00) begin failures++; $display("FAIL sw_done_err got=%b/%b exp=01/00", t.done, t.err); end
    checks++; if (t.we !== 1'b1 || t.addr !== 32'h8000_0010 || t.wdata !== 32'hDEAD_BEEF || t.ctrl !== 3'b010)
      begin failures++; $display("FAIL sw_fields got=%b %h %h %b exp=1 80000010 deadbeef 010", t.we, t.addr, t.wdata, t.ctrl); end
    checks++; if (t.req_pulses !== 1) begin failures++; $display("FAIL sw_req_pulses got=%0d exp=1", t.req_pulses); end
    last_model = 0;
    tick(); w_req = '0;
    checks++; if (w_done !== '0 || w_grant !== '0) begin failures++; $display("FAIL sw_after got=%b/%b exp=0/0", w_done, w_grant); end
  endtask

  task automatic test_read_busy();
    txn_t t;
    set_hart(1, 1'b0, 32'h0000_4000, 32'h0, 3'b100);
    w_req = 2'b10;
    run_txn(5, 32'h1234_5678, 0, t);
    checks++; if (t.hung || t.grant !== 2'b10) begin failures++; $display("FAIL rd_grant got=%b hung=%0d exp=10", t.grant, t.hung); end
    checks++; if (t.done_cyc - t.issue_cyc !== 7) begin failures++; $display("FAIL rd_latency got=%0d exp=7", t.done_cyc - t.issue_cyc); end
    checks++; if (t.rdata !== 32'h1234_5678 || t.err !== '0) begin failures++; $display("FAIL rd_data got=%h err=%b exp=12345678 err=00", t.rdata, t.err); end
    last_model = 1;
    tick(); w_req = '0;
    checks++; if (w_done !== '0) begin failures++; $display("FAIL rd_one_pulse got=%b exp=00", w_done); end
  endtask

  task automatic test_timeout();
    txn_t t;
    set_hart(0, 1'b0, 32'h0000_0100, 32'h0, 3'b000);
    w_req = 2'b01;
    run_txn(100, 32'hFFFF_FFFF, 0, t);
    checks++; if (t.hung || t.done_cyc - t.issue_cyc - 1 !== TO) begin failures++; $display("FAIL to_wait_cycles got=%0d exp=%0d", t.done_cyc - t.issue_cyc - 1, TO); end
    checks++; if (t.done !== 2'b01 || t.err !== 2'b01) begin failures++; $display("FAIL to_done_err got=%b/%b exp=01/01", t.done, t.err); end
    checks++; if (t.rdata !== '0) begin failures++; $display("FAIL to_rdata got=%h exp=0", t.rdata); end
    last_model = 0;
    tick();
    set_hart(1, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 3'b001);
    w_req = 2'b10;
    run_txn(0, 32'h0, 0, t);
    checks++; if (t.hung || t.grant !== 2'b10 || t.err !== '0 || t.done_cyc !== 3) begin failures++; $display("FAIL to_recover got=%b err=%b cyc=%0d exp=10 err=00 cyc=3", t.grant, t.err, t.done_cyc); end
    last_model = 1;
    tick(); w_req = '0;
  endtask

  task automatic test_addr_hold();
    txn_t t;
    set_hart(0, 1'b1, 32'h1000_0040, 32'h0BAD_F00D, 3'b011);
    w_req = 2'b01;
    run_txn(3, 32'h0, 1, t);
    checks++; if (t.hung || !t.stable) begin failures++; $display("FAIL hold_stable got=%0d hung=%0d exp=1", t.stable, t.hung); end
    checks++; if (t.addr !== 32'h1000_0040 || t.wdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL hold_fields got=%h/%h exp=10000040/0badf00d", t.addr, t.wdata); end
    last_model = 0;
    tick(); w_req = '0;
  endtask

  task automatic test_round_robin();
    txn_t t;
    int exp_h; int prev;
    set_hart(0, 1'b1, 32'hA000_0000, 32'h1, 3'b000);
    set_hart(1, 1'b1, 32'hB000_0000, 32'h2, 3'b000);
    w_req = 2'b11;
    prev = last_model;
    for (int i = 0; i < 6; i++) begin
      exp_h = rr_pick(last_model, 2'b11);
      run_txn(i % 3, 32'h0, 0, t);
      checks++; if (t.hung || t.grant !== 2'(1 << exp_h) || t.done !== 2'(1 << exp_h))
        begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, t.grant, 2'(1 << exp_h)); end
      checks++; if (t.addr !== e_addr[exp_h] || exp_h == prev) begin failures++; $display("FAIL rr_alternate[%0d] got=%h exp=%h", i, t.addr, e_addr[exp_h]); end
      prev = exp_h; last_model = exp_h;
      tick();
      checks++; if (w_grant !== '0) begin failures++; $display("FAIL rr_idle_grant[%0d] got=%b exp=00", i, w_grant); end
    end
    w_req = '0;
  endtask

  task automatic test_random();
    txn_t t;
    logic [N-1:0] m; int busy; int exp_h; logic [31:0] rd;
    for (int i = 0; i < 40; i++) begin
      for (int h = 0; h < N; h++) set_hart(h, 1'($urandom), $urandom, $urandom, 3'($urandom));
      m = 2'($urandom_range(1, 3));
      busy = $urandom_range(0, 10);
      rd = $urandom;
      w_req = m;
      exp_h = rr_pick(last_model, m);
      run_txn(busy, rd, 0, t);
      checks++; if (t.hung || t.grant !== 2'(1 << exp_h)) begin failures++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", i, t.grant, 2'(1 << exp_h)); end
      checks++; if (t.we !== e_we[exp_h] || t.addr !== e_addr[exp_h] || t.wdata !== e_wdata[exp_h] || t.ctrl !== e_ctrl[exp_h])
        begin failures++; $display("FAIL rnd_fields[%0d] got=%h/%h exp=%h/%h", i, t.addr, t.wdata, e_addr[exp_h], e_wdata[exp_h]); end
      if (busy < TO) begin
        checks++; if (t.done_cyc - t.issue_cyc !== busy + 2 || t.err !== '0 || t.rdata !== rd)
          begin failures++; $display("FAIL rnd_ok[%0d] got=lat%0d err=%b rd=%h exp=lat%0d err=00 rd=%h", i, t.done_cyc - t.issue_cyc, t.err, t.rdata, busy + 2, rd); end
      end else begin
        checks++; if (t.done_cyc - t.issue_cyc !== TO + 1 || t.err !== 2'(1 << exp_h) || t.rdata !== '0)
          begin failures++; $display("FAIL rnd_abort[%0d] got=lat%0d err=%b rd=%h exp=lat%0d err=%b rd=0", i, t.done_cyc - t.issue_cyc, t.err, t.rdata, TO + 1, 2'(1 << exp_h)); end
      end
      last_model = exp_h;
      tick();
      w_req = '0;
    end
  endtask

  task automatic test_reset_mid();
    txn_t t; bit seen; bit bad_done;
    set_hart(1, 1'b0, 32'h0000_0010, 32'h0, 3'b000);
    w_req = 2'b10;
    run_txn(0, 32'h0, 0, t);
    last_model = 1;
    tick();
    w_req = 2'b11;
    seen = 0;
    w_mem_busy = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (w_mem_req) seen = 1;
    end
    checks++; if (!seen || w_grant !== 2'b01) begin failures++; $display("FAIL rm_pre_grant got=%b seen=%0d exp=01", w_grant, seen); end
    tick(); tick();
    #2 RST_X = 1'b0;
    #1;
    checks++; if (w_grant !== '0 || w_done !== '0 || w_err !== '0 || w_mem_req !== 1'b0 || w_mem_addr !== '0 || w_rdata !== '0)
      begin failures++; $display("FAIL rm_async_clear got=g%b d%b a%h exp=0", w_grant, w_done, w_mem_addr); end
    w_mem_busy = 1'b0;
    bad_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (w_done !== '0 || w_err !== '0) bad_done = 1;
    end
    #2 RST_X = 1'b1;
    checks++; if (bad_done) begin failures++; $display("FAIL rm_no_done got=done exp=none"); end
    last_model = N - 1;
    run_txn(0, 32'h0, 0, t);
    checks++; if (t.hung || t.grant !== 2'b01) begin failures++; $display("FAIL rm_tie_after got=%b exp=01", t.grant); end
    tick(); w_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_busy();
    test_timeout();
    test_addr_hold();
    test_round_robin();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hart_mem_arbiter.md
Name: hart_mem_arbiter

Overview:
- Multi-hart successor to the single-core memory path: arbitrates N_HARTS hart data-memory requests onto one downstream memory/MMU port.
- Round-robin fairness; grant held for the whole transaction; per-hart completion and error strobes.
- A programmable watchdog aborts stuck transactions.
- Sits inside the cluster, between the per-hart cores and the shared DRAM/TLB path.

Parameters:
- N_HARTS, 2, number of requesting harts (1..8).
- DW, 32, data width of write/read data.
- TIMEOUT, 1023, max WAIT cycles before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  clock.
- RST_X  in  1  asynchronous active-low reset.
- w_req  in  N_HARTS  per-hart level request.
- w_we  in  N_HARTS  per-hart write enable.
- w_addr  in  N_HARTS*32  per-hart address; hart i at [32*i +: 32].
- w_wdata  in  N_HARTS*DW  per-hart write data.
- w_ctrl  in  N_HARTS*3  per-hart access size/sign control.
- w_grant  out  N_HARTS  one-hot owner of the downstream port; 0 when idle.
- w_done  out  N_HARTS  one-cycle completion strobe to the owning hart.
- w_err  out  N_HARTS  one-cycle strobe, coincident with w_done, on watchdog abort.
- w_rdata  out  DW  read data; valid only while some w_done bit is high.
- w_mem_req  out  1  one-cycle issue pulse to downstream.
- w_mem_we, w_mem_addr[32], w_mem_wdata[DW], w_mem_ctrl[3]  out  latched request fields; held stable from ISSUE through DONE.
- w_mem_busy  in  1  downstream busy.
- w_mem_rdata  in  DW  downstream read data; sampled when busy is low in WAIT.

Behaviour:
- Reset (RST_X low, asynchronous): state IDLE; all outputs 0; last_grant = N_HARTS-1, so hart 0 has first priority; watchdog counter 0.
- A reset mid-transaction abandons the transaction silently: no done or err strobe.
- All outputs are registered.

State machine (IDLE, ISSUE, WAIT, DONE):
- IDLE:
  - If any w_req bit is set, select the first requesting hart scanning from last_grant+1, wrapping modulo N_HARTS.
  - Latch that hart's we/addr/wdata/ctrl; set w_grant one-hot and last_grant; go to ISSUE.
  - Otherwise remain in IDLE with w_grant = 0.
  - w_req is sampled only in IDLE; changes while granted are ignored.
- ISSUE:
  - w_mem_req = 1 for exactly this cycle.
  - Clear the counter; go to WAIT.
- WAIT:
  - If w_mem_busy == 0: capture w_mem_rdata; go to DONE with err = 0.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: go to DONE with err = 1 and rdata = 0.
  - Else increment the counter; it saturates and never wraps.
- DONE:
  - w_done[g] = 1; w_err[g] = 1 only on abort; w_rdata valid.
  - Go to IDLE.
  - w_grant clears on entry to IDLE.

Timing and handshake:
- Downstream must either complete in the cycle after w_mem_req (busy low) or hold busy high until rdata is valid.
- Minimum latency: request sampled in IDLE at cycle t -> w_mem_req at t+1 -> w_done at t+3.
- A hart must drop w_req in the cycle after w_done (registered reaction). A w_req still high in the following IDLE is treated as a new request.
- Fairness: the just-served hart has lowest priority in the next arbitration, so each contender waits at most N_HARTS-1 transactions.
- Simultaneous requests resolve solely by the round-robin pointer.
- N_HARTS = 1: the pointer is a constant 0 and the scan logic degenerates to a pass-through; the index width is max(1, clog2(N_HARTS)).

Test Plan:
- Single hart 0, write addr 0x8000_0010, wdata 0xDEADBEEF, busy low immediately -> w_mem_req one cycle at t+1 with latched fields; w_done[0] at t+3; w_err = 0.
- Harts 0 and 1 request simultaneously after reset, each repeating on completion -> grants alternate 0,1,0,1; no hart is served twice consecutively while the other is waiting.
- Read with busy held high 5 cycles, mem_rdata = 0x12345678 on the first low cycle -> w_rdata = 0x12345678 with w_done, exactly 1 done pulse.
- TIMEOUT = 8, busy stuck high -> w_done and w_err both high exactly 8 WAIT cycles after ISSUE; w_rdata = 0; next arbitration proceeds normally.
- Hart changes w_addr while granted -> w_mem_addr keeps the latched value through DONE.
- RST_X low during WAIT -> all outputs 0 immediately; no w_done; after release, hart 0 wins a 0/1 tie.
